scr1_tapc_ctrl: RTL and testbench

JTAG TAP controller front end that directly feeds the TAPC data registers. It contains:
- the IEEE 1149.1 16-state TAP FSM driven by tms;
- the instruction register (IR) and its decoder;
- the internal BYPASS and IDCODE registers;
- the TDO output mux and retiming.

It produces the per-DR select, capture, shift and update strobes and the synchronous reset consumed by every downstream data register. It also collects their serial outputs.

---
 rtl/scr1_tapc_pkg.sv | 33 +++
 rtl/scr1_tapc_fsm.sv | 64 ++++++
 rtl/scr1_tapc_ctrl.sv | 132 +++++++++++++
 tb/tb_scr1_tapc_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_tapc_pkg.sv
// Shared TAP controller types and constants: state encoding, IR width, opcodes, IDCODE value.
package scr1_tapc_pkg;

  localparam int SCR1_IR_WIDTH = 5;

  localparam logic [SCR1_IR_WIDTH-1:0] SCR1_IR_IDCODE  = 5'h01;
  localparam logic [SCR1_IR_WIDTH-1:0] SCR1_IR_BYPASS  = 5'h1F;
  localparam logic [SCR1_IR_WIDTH-1:0] SCR1_IR_DTMCS   = 5'h10;
  localparam logic [SCR1_IR_WIDTH-1:0] SCR1_IR_DMI     = 5'h11;
  localparam logic [SCR1_IR_WIDTH-1:0] SCR1_IR_CAPTURE = {{(SCR1_IR_WIDTH-2){1'b0}}, 2'b01};

  localparam logic [31:0] SCR1_IDCODE_VALUE = 32'hDEB11001;

  typedef enum logic [3:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPD_IR
  } tap_state_e;

endpackage

// File: rtl/scr1_tapc_fsm.sv
// IEEE 1149.1 TAP state machine; state register on posedge TCK plus registered-state decodes.
// state    | meaning
// TLR      | test-logic-reset, DR sync reset asserted
// RTI      | run-test/idle
// SEL_*    | select DR / IR scan column
// CAP_*    | capture into shift register
// SHIFT_*  | serial shift tdi -> tdo
// EXIT*/PAUSE_* | scan pause path
// UPD_*    | update from shift register
module scr1_tapc_fsm
  import scr1_tapc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_tms,
  output logic o_tlr,
  output logic o_cap_ir,
  output logic o_shift_ir,
  output logic o_upd_ir,
  output logic o_cap_dr,
  output logic o_shift_dr,
  output logic o_upd_dr
);

  tap_state_e r_state;
  tap_state_e w_state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= TAP_TLR;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TAP_TLR:      w_state_next = i_tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      w_state_next = i_tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   w_state_next = i_tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   w_state_next = i_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: w_state_next = i_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: w_state_next = i_tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: w_state_next = i_tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: w_state_next = i_tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   w_state_next = i_tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   w_state_next = i_tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   w_state_next = i_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: w_state_next = i_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: w_state_next = i_tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: w_state_next = i_tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: w_state_next = i_tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   w_state_next = i_tms ? TAP_SEL_DR   : TAP_RTI;
      default:      w_state_next = TAP_TLR;
    endcase
  end

  assign o_tlr      = (r_state == TAP_TLR);
  assign o_cap_ir   = (r_state == TAP_CAP_IR);
  assign o_shift_ir = (r_state == TAP_SHIFT_IR);
  assign o_upd_ir   = (r_state == TAP_UPD_IR);
  assign o_cap_dr   = (r_state == TAP_CAP_DR);
  assign o_shift_dr = (r_state == TAP_SHIFT_DR);
  assign o_upd_dr   = (r_state == TAP_UPD_DR);

endmodule

// File: rtl/scr1_tapc_ctrl.sv
// TAP controller front end: IR, decoder, BYPASS/IDCODE registers and negedge-retimed TDO.
// Define SCR1_TAPC_IDCODE_EN to include the IDCODE register; otherwise IDCODE decodes as BYPASS.
module scr1_tapc_ctrl
  import scr1_tapc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic                     rst_n_sync,
  output logic [1:0]               fsm_dr_select,
  output logic                     fsm_dr_capture,
  output logic                     fsm_dr_shift,
  output logic                     fsm_dr_update,
  input  logic [1:0]               dr_tdo,
  output logic [SCR1_IR_WIDTH-1:0] ir_value
);

`ifdef SCR1_TAPC_IDCODE_EN
  localparam logic [SCR1_IR_WIDTH-1:0] IR_DEFAULT = SCR1_IR_IDCODE;
`else
  localparam logic [SCR1_IR_WIDTH-1:0] IR_DEFAULT = SCR1_IR_BYPASS;
`endif

  logic w_tlr, w_cap_ir, w_shift_ir, w_upd_ir, w_cap_dr, w_shift_dr, w_upd_dr;
  logic [SCR1_IR_WIDTH-1:0] r_ir_shift;
  logic [SCR1_IR_WIDTH-1:0] r_ir;
  logic r_bypass;
  logic r_tdo, r_tdo_en;
  logic w_sel_dtmcs, w_sel_dmi, w_sel_idcode, w_sel_bypass;
  logic w_idcode_tdo;
  logic w_dr_tdo;

  scr1_tapc_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tms      (tms),
    .o_tlr      (w_tlr),
    .o_cap_ir   (w_cap_ir),
    .o_shift_ir (w_shift_ir),
    .o_upd_ir   (w_upd_ir),
    .o_cap_dr   (w_cap_dr),
    .o_shift_dr (w_shift_dr),
    .o_upd_dr   (w_upd_dr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_ir_shift <= '0;
    else if (w_cap_ir)   r_ir_shift <= SCR1_IR_CAPTURE;
    else if (w_shift_ir) r_ir_shift <= {tdi, r_ir_shift[SCR1_IR_WIDTH-1:1]};
  end

  // IR changes on negedge so the new instruction is stable before the next posedge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)        r_ir <= IR_DEFAULT;
    else if (w_tlr)    r_ir <= IR_DEFAULT;
    else if (w_upd_ir) r_ir <= r_ir_shift;
  end

  always_comb begin
    w_sel_dtmcs  = 1'b0;
    w_sel_dmi    = 1'b0;
    w_sel_idcode = 1'b0;
    case (r_ir)
      SCR1_IR_DTMCS:  w_sel_dtmcs  = 1'b1;
      SCR1_IR_DMI:    w_sel_dmi    = 1'b1;
`ifdef SCR1_TAPC_IDCODE_EN
      SCR1_IR_IDCODE: w_sel_idcode = 1'b1;
`endif
      default: ;
    endcase
  end

  assign w_sel_bypass = ~(w_sel_dtmcs | w_sel_dmi | w_sel_idcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bypass <= 1'b0;
    end else if (w_sel_bypass) begin
      if (w_cap_dr)        r_bypass <= 1'b0;
      else if (w_shift_dr) r_bypass <= tdi;
    end
  end

`ifdef SCR1_TAPC_IDCODE_EN
  logic [31:0] r_idcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idcode <= SCR1_IDCODE_VALUE;
    end else if (w_sel_idcode) begin
      if (w_cap_dr)        r_idcode <= SCR1_IDCODE_VALUE;
      else if (w_shift_dr) r_idcode <= {tdi, r_idcode[31:1]};
    end
  end

  assign w_idcode_tdo = r_idcode[0];
`else
  assign w_idcode_tdo = 1'b0;
`endif

  always_comb begin
    w_dr_tdo = r_bypass;
    if (w_sel_dtmcs)       w_dr_tdo = dr_tdo[0];
    else if (w_sel_dmi)    w_dr_tdo = dr_tdo[1];
    else if (w_sel_idcode) w_dr_tdo = w_idcode_tdo;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo_en <= w_shift_ir | w_shift_dr;
      if (w_shift_ir)      r_tdo <= r_ir_shift[0];
      else if (w_shift_dr) r_tdo <= w_dr_tdo;
      else                 r_tdo <= 1'b0;
    end
  end

  assign tdo            = r_tdo;
  assign tdo_en         = r_tdo_en;
  assign rst_n_sync     = ~w_tlr;
  assign fsm_dr_select  = {w_sel_dmi, w_sel_dtmcs};
  assign fsm_dr_capture = w_cap_dr;
  assign fsm_dr_shift   = w_shift_dr;
  assign fsm_dr_update  = w_upd_dr;
  assign ir_value       = r_ir;

endmodule

// File: tb/tb_scr1_tapc_ctrl.sv
// Scoreboard bench for scr1_tapc_ctrl: expected TDO bits queued by stimulus, popped by a monitor.
module tb_scr1_tapc_ctrl;

`ifdef SCR1_TAPC_IDCODE_EN
  localparam bit IDC_EN = 1'b1;
`else
  localparam bit IDC_EN = 1'b0;
`endif
  localparam logic [4:0]  OP_IDCODE = 5'h01;
  localparam logic [4:0]  OP_BYPASS = 5'h1F;
  localparam logic [4:0]  OP_DTMCS  = 5'h10;
  localparam logic [4:0]  OP_DMI    = 5'h11;
  localparam logic [4:0]  DEF_IR    = IDC_EN ? OP_IDCODE : OP_BYPASS;
  localparam logic [31:0] IDC       = 32'hDEB11001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic [1:0] dr_tdo = 2'b00;
  logic       tdo, tdo_en, rst_n_sync;
  logic [1:0] fsm_dr_select;
  logic       fsm_dr_capture, fsm_dr_shift, fsm_dr_update;
  logic [4:0] ir_value;

  int   total = 0;
  int   bad = 0;
  bit   exp_q[$];
  logic [4:0] m_ir;

  scr1_tapc_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tms            (tms),
    .tdi            (tdi),
    .tdo            (tdo),
    .tdo_en         (tdo_en),
    .rst_n_sync     (rst_n_sync),
    .fsm_dr_select  (fsm_dr_select),
    .fsm_dr_capture (fsm_dr_capture),
    .fsm_dr_shift   (fsm_dr_shift),
    .fsm_dr_update  (fsm_dr_update),
    .dr_tdo         (dr_tdo),
    .ir_value       (ir_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_sel(input logic [4:0] ir);
    if (ir == OP_DMI)   return 2'b10;
    if (ir == OP_DTMCS) return 2'b01;
    return 2'b00;
  endfunction

  // DR scan output: what the selected register holds at capture, followed by the tdi stream.
  function automatic logic [63:0] model_dr(input int n, input logic [63:0] din,
                                           input logic [63:0] d0, input logic [63:0] d1);
    logic [63:0] r;
    logic [31:0] idc;
    r = '0;
    idc = IDC;
    for (int k = 0; k < n; k++) begin
      if (m_ir == OP_DTMCS)                 r[k] = d0[k];
      else if (m_ir == OP_DMI)              r[k] = d1[k];
      else if (IDC_EN && m_ir == OP_IDCODE) r[k] = (k < 32) ? idc[k] : din[k-32];
      else                                  r[k] = (k == 0) ? 1'b0 : din[k-1];
    end
    return r;
  endfunction

  task automatic tick(input logic t);
    tms = t;
    @(posedge clk);
    #1;
  endtask

  task automatic tap_reset();
    repeat (5) tick(1'b1);
    tick(1'b0);
    m_ir = DEF_IR;
  endtask

  task automatic scan_ir(input logic [4:0] op);
    for (int k = 0; k < 5; k++) exp_q.push_back(k == 0);
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
    for (int k = 0; k < 5; k++) begin
      tdi = op[k];
      tick(k == 4);
    end
    tick(1'b1);
    chk("ir_before_update", 32'(ir_value), 32'(m_ir));
    @(negedge clk);
    #1;
    m_ir = op;
    chk("ir_value", 32'(ir_value), 32'(m_ir));
    chk("dr_select", 32'(fsm_dr_select), 32'(exp_sel(m_ir)));
    tick(1'b0);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din,
                         input logic [63:0] d0, input logic [63:0] d1);
    logic [63:0] e;
    e = model_dr(n, din, d0, d1);
    for (int k = 0; k < n; k++) exp_q.push_back(e[k]);
    tick(1'b1);
    tick(1'b0);
    chk("dr_capture", 32'(fsm_dr_capture), 32'd1);
    tick(1'b0);
    chk("dr_capture_one_cycle", 32'(fsm_dr_capture), 32'd0);
    chk("dr_shift", 32'(fsm_dr_shift), 32'd1);
    dr_tdo = {d1[0], d0[0]};
    for (int k = 0; k < n; k++) begin
      tdi = din[k];
      tick(k == n - 1);
      if (k + 1 < n) dr_tdo = {d1[k+1], d0[k+1]};
    end
    chk("dr_shift_exit", 32'(fsm_dr_shift), 32'd0);
    tick(1'b1);
    chk("dr_update", 32'(fsm_dr_update), 32'd1);
    tick(1'b0);
    chk("dr_update_one_cycle", 32'(fsm_dr_update), 32'd0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (tdo_en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tdo_unexpected: tdo_en=1 tdo=%0b with nothing expected at %0t", tdo, $time);
        end else begin
          chk("tdo", 32'(tdo), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    total++;
    bad++;
    $display("FAIL watchdog: run exceeded time budget");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stim
    logic [63:0] din, d0, d1;
    logic [4:0]  op;
    int          n;
    m_ir = DEF_IR;

    #3 rst_n = 1'b0;
    #4;
    chk("rst_ir_value", 32'(ir_value), 32'(DEF_IR));
    chk("rst_rst_n_sync", 32'(rst_n_sync), 32'd0);
    chk("rst_tdo_en", 32'(tdo_en), 32'd0);
    chk("rst_tdo", 32'(tdo), 32'd0);
    chk("rst_strobes", 32'({fsm_dr_capture, fsm_dr_shift, fsm_dr_update}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b1);
    chk("tlr_hold_rst_n_sync", 32'(rst_n_sync), 32'd0);
    tick(1'b0);
    chk("rti_rst_n_sync", 32'(rst_n_sync), 32'd1);

    // IR readout of the capture pattern, shifting all ones (BYPASS)
    scan_ir(5'h1F);

    // IDCODE / bypass scan straight after a TMS reset
    tap_reset();
    din = {$urandom, $urandom};
    scan_dr(40, din, 64'd0, 64'd0);

    // user DR selection
    scan_ir(OP_DMI);
    scan_dr(16, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    scan_ir(OP_DTMCS);
    scan_dr(12, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});

    // unknown opcode behaves as one-bit bypass
    scan_ir(5'h07);
    scan_dr(4, 64'hD, 64'd0, 64'd0);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 4))
        0:       op = OP_IDCODE;
        1:       op = OP_DTMCS;
        2:       op = OP_DMI;
        3:       op = OP_BYPASS;
        default: op = 5'($urandom_range(0, 31));
      endcase
      n  = $urandom_range(1, 40);
      din = {$urandom, $urandom};
      d0  = {$urandom, $urandom};
      d1  = {$urandom, $urandom};
      scan_ir(op);
      scan_dr(n, din, d0, d1);
    end

    // five TMS=1 clocks from Pause-DR reach Test-Logic-Reset
    scan_ir(OP_DMI);
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
    repeat (4) tick(1'b1);
    chk("tms_reset_4th", 32'(rst_n_sync), 32'd1);
    tick(1'b1);
    chk("tms_reset_tlr", 32'(rst_n_sync), 32'd0);
    @(negedge clk);
    #1;
    m_ir = DEF_IR;
    chk("tms_reset_ir", 32'(ir_value), 32'(DEF_IR));
    chk("tms_reset_sel", 32'(fsm_dr_select), 32'd0);
    tick(1'b0);

    // asynchronous reset three bits into an IR shift
    scan_ir(OP_DMI);
    for (int k = 0; k < 3; k++) exp_q.push_back(k == 0);
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
    tdi = 1'b0;
    repeat (3) tick(1'b0);
    rst_n = 1'b0;
    #1;
    m_ir = DEF_IR;
    chk("async_rst_tdo_en", 32'(tdo_en), 32'd0);
    chk("async_rst_n_sync", 32'(rst_n_sync), 32'd0);
    chk("async_rst_ir", 32'(ir_value), 32'(DEF_IR));
    tms = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b1);
    tick(1'b0);
    chk("post_rst_ir", 32'(ir_value), 32'(DEF_IR));
    scan_dr(36, {$urandom, $urandom}, 64'd0, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
